board_ram_responder: RTL and testbench
======================================

BOARD_RAM_RESPONDER -- requirements
Module: board_ram_responder

Interface
REQ-001 SHALL have parameter NUM_BOARDS, default 8, the number of 64-word board images held (word depth = 64*NUM_BOARDS).
REQ-002 SHALL have parameter READ_LATENCY, default 2 (legal 1..4), the cycles from read acceptance to slave_readdatavalid.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1 (legal 0..7), the waitrequest stall cycles inserted before each command is accepted.
REQ-004 SHALL have port clk, input, 1 bit, the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port slave_address, input, 32 bits, byte address; word index = slave_address[31:2].
REQ-007 SHALL have port slave_read, input, 1 bit, read request.
REQ-008 SHALL have port slave_write, input, 1 bit, write request.
REQ-009 SHALL have port slave_writedata, input, 32 bits, write data.
REQ-010 SHALL have port slave_waitrequest, output, 1 bit, command not accepted this cycle.
REQ-011 SHALL have port slave_readdata, output, 32 bits, read data, qualified by slave_readdatavalid.
REQ-012 SHALL have port slave_readdatavalid, output, 1 bit, one-cycle read-return strobe.
REQ-013 SHALL have port err, output, 1 bit, sticky protocol/range error flag.
REQ-014 SHALL have ports rd_count and wr_count, output, 16 bits each, accepted-command counters.

Function
REQ-015 SHALL be the Avalon-MM responder serving the move-generator master ports (board reads, child-board writes).
REQ-016 SHALL run a stall counter: with slave_read or slave_write high and counter < WAIT_CYCLES, assert slave_waitrequest and increment the counter.
REQ-017 SHALL accept a command in the cycle where the request is high and counter == WAIT_CYCLES (slave_waitrequest low), then clear the counter.
REQ-018 SHALL drive slave_waitrequest low whenever neither slave_read nor slave_write is high; with WAIT_CYCLES=0, SHALL accept one command per cycle.
REQ-019 SHALL clear the stall counter if the request drops before acceptance; a dropped request SHALL have no effect.
REQ-020 SHALL, on accepted write with word index < 64*NUM_BOARDS, store slave_writedata at that word on the next clock edge.
REQ-021 SHALL, on accepted read, sample the word as of the acceptance cycle and return it with slave_readdatavalid high exactly READ_LATENCY cycles later, for one cycle.
REQ-022 SHALL pipeline reads: up to READ_LATENCY reads in flight, returned in acceptance order with no bubbles.
REQ-023 SHALL return old data for a read accepted in the same cycle as an earlier-accepted write's storage edge is pending; a read accepted after the write's acceptance cycle SHALL return new data.
REQ-024 SHALL, on out-of-range word index, drop writes, return 32'hFFFFFFFF for reads (with normal latency), and set err.
REQ-025 SHALL, when slave_read and slave_write are both high, treat the command as a write only (no read return) and set err.
REQ-026 SHALL drive slave_readdata to 32'h0 when slave_readdatavalid is low.
REQ-027 SHALL increment rd_count/wr_count on each accepted read/write, saturating at 16'hFFFF.
REQ-028 SHALL keep err set until reset.

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear stall counter, read pipeline, rd_count, wr_count, err; slave_waitrequest=0, slave_readdatavalid=0, slave_readdata=0.
REQ-030 SHALL discard in-flight reads when reset asserts mid-operation; no readdatavalid SHALL follow reset release for them.
REQ-031 SHALL NOT reset memory contents; unwritten words read as undefined.

Verification
REQ-032 Defaults: write 32'h5 to 0x104, then read 0x104 -> waitrequest high 1 cycle per command, readdatavalid 2 cycles after read acceptance with 32'h00000005; wr_count=1, rd_count=1.
REQ-033 WAIT_CYCLES=0, READ_LATENCY=3: back-to-back reads of 0x0,0x4,0x8 (preloaded 1,2,3) -> readdatavalid high 3 consecutive cycles returning 1,2,3.
REQ-034 Read 0x800 (index 512, NUM_BOARDS=8) -> 32'hFFFFFFFF after latency, err=1; write to 0x800 then in-range reads unchanged.
REQ-035 Read and write both high to 0x10 with 32'hA -> no readdatavalid, word 4 = 32'hA, err=1.
REQ-036 Reset asserted one cycle after read acceptance -> readdatavalid never pulses, counters 0, err 0.
REQ-037 Drive move-generator-style sequence (64 reads board 0, 64 writes to 0x100..0x1FC) -> board 1 image equals board 0 image; rd_count=64, wr_count=64.

Source files
------------

// File: rtl/board_ram_responder.sv
// Avalon-MM word RAM holding NUM_BOARDS 64-word board images for the move generator.
// Fixed-latency pipelined reads, programmable waitrequest stall, sticky range/protocol error.
module board_ram_responder #(
    parameter int NUM_BOARDS   = 8,
    parameter int READ_LATENCY = 2,
    parameter int WAIT_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic        slave_waitrequest,
    output logic [31:0] slave_readdata,
    output logic        slave_readdatavalid,
    output logic        err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    localparam int DEPTH = 64 * NUM_BOARDS;
    localparam int AW    = $clog2(DEPTH);

    logic [2:0]  r_wait_cnt;
    logic [31:0] r_mem [DEPTH];
    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [31:0] r_pipe_data [READ_LATENCY];
    logic        r_err;
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    logic        w_req;
    logic        w_accept;
    logic        w_acc_rd;
    logic        w_acc_wr;
    logic        w_in_range;
    logic [29:0] w_word_idx;
    logic [AW-1:0] w_mem_idx;
    logic [31:0] w_rd_word;
    logic        w_unused;

    // Handshake: a command (read or write high) is accepted on the rising edge where
    // slave_waitrequest is low; the master holds address/data stable until then.
    assign w_req             = (slave_read | slave_write) & rst_n;
    assign slave_waitrequest = w_req && (r_wait_cnt != 3'(WAIT_CYCLES));
    assign w_accept          = w_req && (r_wait_cnt == 3'(WAIT_CYCLES));
    assign w_acc_wr          = w_accept & slave_write;
    assign w_acc_rd          = w_accept & slave_read & ~slave_write;

    assign w_word_idx = slave_address[31:2];
    assign w_in_range = (w_word_idx < 30'(DEPTH));
    assign w_mem_idx  = w_word_idx[AW-1:0];
    assign w_unused   = ^slave_address[1:0];

    // Read sees memory before this edge's write lands, so it returns the pre-write word.
    assign w_rd_word = w_in_range ? r_mem[w_mem_idx] : 32'hFFFF_FFFF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 3'd0;
        end else if (!w_req || w_accept) begin
            r_wait_cnt <= 3'd0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc_wr && w_in_range) begin
            r_mem[w_mem_idx] <= slave_writedata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_data[i] <= 32'h0;
            end
        end else begin
            r_pipe_vld[0]  <= w_acc_rd;
            r_pipe_data[0] <= w_acc_rd ? w_rd_word : 32'h0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_data[i] <= r_pipe_data[i-1];
            end
        end
    end

    assign slave_readdatavalid = r_pipe_vld[READ_LATENCY-1];
    assign slave_readdata      = slave_readdatavalid ? r_pipe_data[READ_LATENCY-1] : 32'h0;

    // Error is sticky: out-of-range access, or read and write asserted together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && (!w_in_range || (slave_read && slave_write))) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= 16'd0;
            r_wr_count <= 16'd0;
        end else begin
            if (w_acc_rd && (r_rd_count != 16'hFFFF)) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (w_acc_wr && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign err      = r_err;
    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
endmodule

// File: tb/tb_board_ram_responder.sv
// Bench for board_ram_responder: default instance plus a zero-wait, latency-3 instance.
// Directed table, hand sequences for reset/pipelining corners, and randomized traffic.
module tb_board_ram_responder;
    localparam int DEPTH = 512;
    localparam int LAT   = 2;
    localparam int WAITC = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic [31:0] slave_address = '0, slave_writedata = '0;
    logic        slave_read = 1'b0, slave_write = 1'b0;
    logic        slave_waitrequest, slave_readdatavalid, err;
    logic [31:0] slave_readdata;
    logic [15:0] rd_count, wr_count;

    logic [31:0] f_address = '0, f_writedata = '0;
    logic        f_read = 1'b0, f_write = 1'b0;
    logic        f_waitrequest, f_readdatavalid, f_err;
    logic [31:0] f_readdata;
    logic [15:0] f_rd_count, f_wr_count;

    board_ram_responder u_dut (
        .clk(clk), .rst_n(rst_n),
        .slave_address(slave_address), .slave_read(slave_read),
        .slave_write(slave_write), .slave_writedata(slave_writedata),
        .slave_waitrequest(slave_waitrequest), .slave_readdata(slave_readdata),
        .slave_readdatavalid(slave_readdatavalid), .err(err),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    board_ram_responder #(.NUM_BOARDS(8), .READ_LATENCY(3), .WAIT_CYCLES(0)) u_dut_fast (
        .clk(clk), .rst_n(rst_n),
        .slave_address(f_address), .slave_read(f_read),
        .slave_write(f_write), .slave_writedata(f_writedata),
        .slave_waitrequest(f_waitrequest), .slave_readdata(f_readdata),
        .slave_readdatavalid(f_readdatavalid), .err(f_err),
        .rd_count(f_rd_count), .wr_count(f_wr_count)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: word array, expected read returns with due cycle, counters, error flag.
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_q[$];
    int          due_q[$];
    int          m_rd = 0, m_wr = 0;
    logic        m_err = 1'b0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [15:0] exp_rd;
        logic [15:0] exp_wr;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [31:0] pattern(input int i);
        return 32'hB0A0_0000 + 32'(i * 7);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_rdv", {31'b0, slave_readdatavalid}, 32'h0);
            check("rst_rdata", slave_readdata, 32'h0);
        end else if (slave_readdatavalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got readdatavalid with %h, expected none (cycle %0d)",
                         slave_readdata, cyc);
            end else begin
                check("rd_data", slave_readdata, exp_q.pop_front());
                check("rd_cycle", 32'(cyc), 32'(due_q.pop_front()));
            end
        end else begin
            check("rdata_idle", slave_readdata, 32'h0);
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                checks++;
                errors++;
                $display("FAIL rd_missing: got no readdatavalid, expected %h at cycle %0d",
                         exp_q[0], due_q[0]);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
        end
    end

    task automatic model_accept(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] data, input bit use_tbl,
                                input logic [31:0] tbl_data);
        int widx;
        bit in_rng;
        widx   = int'(addr[31:2]);
        in_rng = (widx < DEPTH);
        if (wr) begin
            if (in_rng) ref_mem[widx] = data;
            else m_err = 1'b1;
            if (rd) m_err = 1'b1;
            if (m_wr < 65535) m_wr++;
        end else begin
            if (!in_rng) m_err = 1'b1;
            exp_q.push_back(use_tbl ? tbl_data : (in_rng ? ref_mem[widx] : 32'hFFFF_FFFF));
            due_q.push_back(cyc + LAT);
            if (m_rd < 65535) m_rd++;
        end
    endtask

    task automatic do_cmd(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input bit use_tbl,
                          input logic [31:0] tbl_data, output int stalls);
        bit done;
        stalls = 0;
        done   = 1'b0;
        @(negedge clk);
        slave_read = rd; slave_write = wr; slave_address = addr; slave_writedata = data;
        #1;
        for (int i = 0; i < 10 && !done; i++) begin
            if (!slave_waitrequest) begin
                model_accept(rd, wr, addr, data, use_tbl, tbl_data);
                done = 1'b1;
                @(posedge clk);
                #1;
            end else begin
                stalls++;
                @(negedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL cmd_timeout: got waitrequest stuck for addr %h, expected acceptance", addr);
        end
        slave_read = 1'b0; slave_write = 1'b0;
    endtask

    task automatic cmd_chk(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data);
        int st;
        do_cmd(rd, wr, addr, data, 1'b0, 32'h0, st);
        check("stall", 32'(st), 32'(WAITC));
    endtask

    // Request raised for one stalled cycle then withdrawn; must leave no trace.
    task automatic drop_cmd(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        slave_write = 1'b1; slave_address = addr; slave_writedata = data;
        #1;
        check("drop_wait", {31'b0, slave_waitrequest}, 32'h1);
        @(posedge clk);
        #1;
        slave_write = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete(); due_q.delete();
        m_rd = 0; m_wr = 0; m_err = 1'b0;
        slave_read = 1'b1; slave_address = 32'h0;
        @(negedge clk);
        #1;
        check("rst_wait", {31'b0, slave_waitrequest}, 32'h0);
        check("rst_rd_count", {16'h0, rd_count}, 32'h0);
        check("rst_wr_count", {16'h0, wr_count}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        slave_read = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected completion within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, t0, kind, r, w;
        logic [31:0] a;

        tbl[0] = '{1'b0, 1'b1, 32'h104, 32'h5,        32'h0,        1'b0, 16'd0, 16'd1};
        tbl[1] = '{1'b1, 1'b0, 32'h104, 32'h0,        32'h5,        1'b0, 16'd1, 16'd1};
        tbl[2] = '{1'b1, 1'b0, 32'h800, 32'h0,        32'hFFFFFFFF, 1'b1, 16'd2, 16'd1};
        tbl[3] = '{1'b0, 1'b1, 32'h800, 32'hDEADBEEF, 32'h0,        1'b1, 16'd2, 16'd2};
        tbl[4] = '{1'b1, 1'b0, 32'h000, 32'h0,        pattern(0),   1'b1, 16'd3, 16'd2};
        tbl[5] = '{1'b1, 1'b0, 32'h7FC, 32'h0,        pattern(511), 1'b1, 16'd4, 16'd2};
        tbl[6] = '{1'b1, 1'b1, 32'h010, 32'hA,        32'h0,        1'b1, 16'd4, 16'd3};
        tbl[7] = '{1'b1, 1'b0, 32'h010, 32'h0,        32'hA,        1'b1, 16'd5, 16'd3};

        do_reset();

        // Zero-wait, latency-3 instance: three writes then back-to-back reads.
        @(negedge clk); f_write = 1'b1; f_address = 32'h0; f_writedata = 32'h1;
        #1 check("f_wait_wr", {31'b0, f_waitrequest}, 32'h0);
        @(negedge clk); f_address = 32'h4; f_writedata = 32'h2;
        #1 check("f_wait_wr", {31'b0, f_waitrequest}, 32'h0);
        @(negedge clk); f_address = 32'h8; f_writedata = 32'h3;
        #1 check("f_wait_wr", {31'b0, f_waitrequest}, 32'h0);
        @(negedge clk); f_write = 1'b0; f_read = 1'b1; f_address = 32'h0; t0 = cyc;
        #1 check("f_wait_rd", {31'b0, f_waitrequest}, 32'h0);
        @(negedge clk); f_address = 32'h4;
        @(negedge clk); f_address = 32'h8;
        check("f_rdv_early", {31'b0, f_readdatavalid}, 32'h0);
        @(negedge clk); f_read = 1'b0;
        check("f_t0", 32'(cyc - t0), 32'd3);
        for (int j = 0; j < 5; j++) begin
            check("f_rdv", {31'b0, f_readdatavalid}, (j < 3) ? 32'h1 : 32'h0);
            check("f_rdata", f_readdata, (j < 3) ? 32'(j + 1) : 32'h0);
            @(negedge clk);
        end
        check("f_rd_count", {16'h0, f_rd_count}, 32'd3);
        check("f_wr_count", {16'h0, f_wr_count}, 32'd3);

        // Preload every word, then reset: memory contents survive reset.
        for (int i = 0; i < DEPTH; i++) cmd_chk(1'b0, 1'b1, 32'(i * 4), pattern(i));
        do_reset();

        for (int i = 0; i < 8; i++) begin
            do_cmd(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b1, tbl[i].exp_rdata, st);
            check("tbl_stall", 32'(st), 32'(WAITC));
            check("tbl_err", {31'b0, err}, {31'b0, tbl[i].exp_err});
            check("tbl_rd_count", {16'h0, rd_count}, {16'h0, tbl[i].exp_rd});
            check("tbl_wr_count", {16'h0, wr_count}, {16'h0, tbl[i].exp_wr});
        end
        drain();

        // Reset one cycle after a read is accepted: the return must never appear.
        cmd_chk(1'b1, 1'b0, 32'h104, 32'h0);
        do_reset();
        repeat (6) @(negedge clk);
        check("post_rst_rd_count", {16'h0, rd_count}, 32'h0);
        check("post_rst_err", {31'b0, err}, 32'h0);

        // Read and write together: write only, error set, no return.
        cmd_chk(1'b1, 1'b1, 32'h14, 32'hB);
        check("rw_err", {31'b0, err}, 32'h1);
        check("rw_rd_count", {16'h0, rd_count}, 32'h0);
        cmd_chk(1'b1, 1'b0, 32'h14, 32'h0);
        drain();

        // Move-generator style copy of board 0 into board 1.
        do_reset();
        for (int i = 0; i < 64; i++) cmd_chk(1'b1, 1'b0, 32'(i * 4), 32'h0);
        for (int i = 0; i < 64; i++) cmd_chk(1'b0, 1'b1, 32'(256 + i * 4), ref_mem[i]);
        check("mg_rd_count", {16'h0, rd_count}, 32'd64);
        check("mg_wr_count", {16'h0, wr_count}, 32'd64);
        check("mg_err", {31'b0, err}, 32'h0);
        for (int i = 0; i < 64; i++) begin
            do_cmd(1'b1, 1'b0, 32'(256 + i * 4), 32'h0, 1'b1, ref_mem[i], st);
        end
        drain();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            w    = ($urandom_range(0, 9) == 0) ? DEPTH + $urandom_range(0, 63)
                                               : $urandom_range(0, DEPTH - 1);
            a    = 32'(w * 4);
            if (kind == 0) begin
                drop_cmd(32'($urandom_range(0, DEPTH - 1) * 4), $urandom);
            end else if (kind == 1) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end else begin
                r = $urandom_range(0, 9);
                if (r < 5)      cmd_chk(1'b1, 1'b0, a, 32'h0);
                else if (r < 9) cmd_chk(1'b0, 1'b1, a, $urandom);
                else            cmd_chk(1'b1, 1'b1, a, $urandom);
            end
        end
        drain();
        check("rnd_rd_count", {16'h0, rd_count}, 32'(m_rd));
        check("rnd_wr_count", {16'h0, wr_count}, 32'(m_wr));
        check("rnd_err", {31'b0, err}, {31'b0, m_err});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
